// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one finished FU per cycle and registers its tag/result onto the CDB.
// Build option CDB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module cdb_arbiter #(
    parameter int N_FU  = 9,
    parameter int DW    = 32,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_FU-1:0]      finish,
    input  logic [N_FU*DW-1:0]   fu_res,
    input  logic                 cdb_stall,
    output logic [N_FU-1:0]      CDB_result,
    output logic                 cdb_valid,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [DW-1:0]        cdb_data
);

    // Handshake: an FU raises finish and holds it, with fu_res stable, until it sees its own
    // bit in CDB_result; that bit is the acknowledge and the FU drops finish at the next edge.
    logic [N_FU-1:0]  req;
    logic [N_FU-1:0]  grant_vec;
    logic             grant_found;
    logic [TAG_W-1:0] grant_idx;
    logic [DW-1:0]    grant_data;

    // The FU on the bus this cycle is masked so it cannot be re-granted back-to-back.
    assign req = finish & ~CDB_result;

`ifdef CDB_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        grant_data  = '0;
        for (int j = 0; j < N_FU; j++) begin
            if (!grant_found && req[j]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'(j);
                grant_vec[j] = 1'b1;
                grant_data  = fu_res[j*DW +: DW];
            end
        end
    end
`else
    logic [TAG_W-1:0] rr_ptr;

    // First pass covers rr_ptr..N_FU-1; the second pass only wins when nothing there
    // requested, which gives the wrap back to index 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        grant_data  = '0;
        for (int j = 0; j < N_FU; j++) begin
            if (!grant_found && req[j] && (TAG_W'(j) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'(j);
                grant_vec[j] = 1'b1;
                grant_data  = fu_res[j*DW +: DW];
            end
        end
        for (int j = 0; j < N_FU; j++) begin
            if (!grant_found && req[j]) begin
                grant_found = 1'b1;
                grant_idx   = TAG_W'(j);
                grant_vec[j] = 1'b1;
                grant_data  = fu_res[j*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!cdb_stall && grant_found) begin
            rr_ptr <= (grant_idx == TAG_W'(N_FU - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CDB_result <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end else if (!cdb_stall && grant_found) begin
            CDB_result <= grant_vec;
            cdb_valid  <= 1'b1;
            cdb_tag    <= grant_idx;
            cdb_data   <= grant_data;
        end else begin
            CDB_result <= '0;
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; a small FU model drops finish one edge after its ack.
module tb_cdb_arbiter;
    localparam int N_FU  = 9;
    localparam int DW    = 32;
    localparam int TAG_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [N_FU-1:0]     finish = '0;
    logic [N_FU*DW-1:0]  fu_res = '0;
    logic                cdb_stall = 1'b0;
    logic [N_FU-1:0]     CDB_result;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DW-1:0]       cdb_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [N_FU-1:0] lag_mask = '0;

    cdb_arbiter #(.N_FU(N_FU), .DW(DW), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .finish(finish), .fu_res(fu_res), .cdb_stall(cdb_stall),
        .CDB_result(CDB_result), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fu_val(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: the FU model clears finish for bits it saw acknowledged (unless lagging), then raises new ones.
    task automatic step(input logic [N_FU-1:0] raise);
        logic [N_FU-1:0] seen;
        @(negedge clk);
        seen = CDB_result;
        @(posedge clk);
        #1;
        finish = (finish & ~(seen & ~lag_mask)) | raise;
    endtask

    task automatic expect_grant(input string tag, input int g, input logic [DW-1:0] d);
        logic [N_FU-1:0] oh;
        oh = '0;
        oh[g] = 1'b1;
        check({tag, ".valid"}, 32'(cdb_valid), 32'd1);
        check({tag, ".tag"}, 32'(cdb_tag), 32'(g));
        check({tag, ".onehot"}, 32'(CDB_result), 32'(oh));
        check({tag, ".data"}, cdb_data, d);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".valid"}, 32'(cdb_valid), 32'd0);
        check({tag, ".onehot"}, 32'(CDB_result), 32'd0);
        check({tag, ".tag"}, 32'(cdb_tag), 32'd0);
        check({tag, ".data"}, cdb_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < N_FU; i++) fu_res[i*DW +: DW] = fu_val(i);

        // Reset with every FU requesting; outputs must be clear without a clock edge.
        finish = 9'h1FF;
        #1 rst = 1'b1;
        #1;
        expect_idle("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N_FU; i++) begin
            step('0);
            expect_grant($sformatf("rst_order%0d", i), i, fu_val(i));
        end
        step('0);
        expect_idle("rst_drain");
        step('0);

        // Single request, two-edge latency, then idle.
        fu_res[3*DW +: DW] = 32'hDEAD_BEEF;
        step(9'h008);
        check("single_not_early", 32'(cdb_valid), 32'd0);
        step('0);
        expect_grant("single", 3, 32'hDEAD_BEEF);
        step('0);
        expect_idle("single_after");

        // FU2 lags one cycle dropping finish; the next cycle must not regrant it.
        step(9'h004);
        step('0);
        expect_grant("lag_grant", 2, fu_val(2));
        lag_mask = 9'h004;
        step('0);
        lag_mask = '0;
        check("lag_no_regrant", 32'(CDB_result[2]), 32'd0);
        expect_idle("lag_idle");
        finish = '0;
        step('0);

        // Grant FU0 first so the pointer sits at 1, then FU1/FU5 request every cycle.
        step(9'h001);
        step('0);
        expect_grant("rr_pre", 0, fu_val(0));
        step(9'h022);
        check("rr_gap", 32'(cdb_valid), 32'd0);
        step(9'h022);
        expect_grant("rr_a", 1, fu_val(1));
        step(9'h022);
        expect_grant("rr_b", 5, fu_val(5));
        step(9'h022);
        expect_grant("rr_c", 1, fu_val(1));
        step(9'h022);
        expect_grant("rr_d", 5, fu_val(5));
        finish = '0;
        step('0);
        expect_idle("rr_end");

        // Stall for three cycles with FU0 and FU4 waiting; nothing may be lost.
        cdb_stall = 1'b1;
        step(9'h011);
        for (int i = 0; i < 3; i++) begin
            step('0);
            expect_idle($sformatf("stall%0d", i));
        end
        cdb_stall = 1'b0;
        step('0);
        expect_grant("stall_rel0", 0, fu_val(0));
        step('0);
        expect_grant("stall_rel4", 4, fu_val(4));
        step('0);
        expect_idle("stall_done");

        // Move the pointer to 8 via FU7, then FU8 and FU0 request together.
        step(9'h080);
        step('0);
        expect_grant("wrap_pre", 7, fu_val(7));
        step(9'h101);
        check("wrap_gap", 32'(cdb_valid), 32'd0);
        step('0);
        expect_grant("wrap_8", 8, fu_val(8));
        step('0);
        expect_grant("wrap_0", 0, fu_val(0));
        step('0);
        expect_idle("wrap_idle");
        // Pointer now at 1: FU0 and FU2 together should favour FU2 under round-robin.
        step(9'h005);
        step('0);
`ifdef CDB_FIXED_PRIO_EN
        expect_grant("wrap_ptr", 0, fu_val(0));
`else
        expect_grant("wrap_ptr", 2, fu_val(2));
`endif
        finish = '0;
        step('0);

        // Reset in the middle of a broadcast; the unacknowledged FU6 is re-arbitrated.
        step(9'h040);
        step('0);
        expect_grant("mid_rst_pre", 6, fu_val(6));
        rst = 1'b1;
        #1;
        expect_idle("mid_rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_finish_held", 32'(finish), 32'h040);
        step('0);
        expect_grant("mid_rst_regrant", 6, fu_val(6));
        step('0);
        expect_idle("mid_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
